// File: rtl/passthrough_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin pass-through arbiter.
// rr_pick returns the winning requester index, or -1 when nobody is requesting.
package passthrough_rr_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int WIDTH_DEFAULT   = 10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Scan starts just after the previous winner and wraps modulo n.
  function automatic int rr_pick(input logic [7:0] req, input int last, input int n);
    int cand;
    int win;
    win = -1;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && win < 0) begin
        cand = last + k;
        if (cand >= n) begin
          cand = cand - n;
        end
        if (req[cand[2:0]]) begin
          win = cand;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/passthrough_rr_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the downstream stage.
interface passthrough_rr_arbiter_if
  import passthrough_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int SRC_W   = clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*WIDTH-1:0] in_bits;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_bits;
  logic [SRC_W-1:0]         out_src;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_src
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_src
  );

endinterface

// File: rtl/passthrough_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant plus index of the winner.
module rr_picker
  import passthrough_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int SRC_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  logic [7:0] req_pad;
  int         pick;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    pick = rr_pick(req_pad, int'(last), NUM_REQ);
    any  = en && (pick >= 0);
    idx  = any ? SRC_W'(pick) : '0;
    gnt  = '0;
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/passthrough_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output slot; a new word may
// be loaded in the same cycle the held word drains.
module passthrough_rr_arbiter
  import passthrough_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int SRC_W   = clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  passthrough_rr_arbiter_if.slave  io,
  output logic [15:0]              io_grant_cnt
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;

  logic               can_load;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   win;
  logic               win_any;

  // Grants are suppressed while reset is held so nothing transfers.
  assign can_load = ((state_q == EMPTY) || io.out_ready) && reset;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .SRC_W  (SRC_W)
  ) u_picker (
    .req (io.in_valid),
    .last(last_q),
    .en  (can_load),
    .gnt (gnt),
    .idx (win),
    .any (win_any)
  );

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    src_d   = src_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (win_any) begin
      state_d = FULL;
      bits_d  = io.in_bits[win*WIDTH +: WIDTH];
      src_d   = win;
      last_d  = win;
      cnt_d   = cnt_q + 16'd1;
    end else if (state_q == FULL && io.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= EMPTY;
      bits_q  <= '0;
      src_q   <= '0;
      last_q  <= SRC_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready   = gnt;
  assign io.out_valid  = (state_q == FULL);
  assign io.out_bits   = bits_q;
  assign io.out_src    = src_q;
  assign io_grant_cnt  = cnt_q;

endmodule

// File: tb/tb_passthrough_rr_arbiter.sv
// Directed-vector bench for passthrough_rr_arbiter (NUM_REQ=4, WIDTH=10).
module tb_passthrough_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 10;

  logic        clock;
  logic        reset;
  logic [15:0] grant_cnt;
  int          checks;
  int          failures;

  passthrough_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) io_if ();

  passthrough_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .io          (io_if),
    .io_grant_cnt(grant_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_bits(input int i, input logic [WIDTH-1:0] v);
    io_if.in_bits[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic pulse_reset();
    io_if.in_valid = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    io_if.in_valid  = 4'b1111;
    io_if.out_ready = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      checks++;
      if (io_if.in_ready !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_ready got=%b exp=0000", io_if.in_ready);
      end
    end
    checks++;
    if (io_if.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b exp=0", io_if.out_valid);
    end
    checks++;
    if (io_if.out_bits !== 10'h000 || io_if.out_src !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_out_data got=%h/%0d exp=000/0", io_if.out_bits, io_if.out_src);
    end
    checks++;
    if (grant_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_grant_cnt got=%0d exp=0", grant_cnt);
    end
    io_if.in_valid = '0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    pulse_reset();
    io_if.in_valid  = 4'b0100;
    io_if.out_ready = 1'b1;
    set_bits(2, 10'h155);
    #1;
    checks++;
    if (io_if.in_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL single_ready got=%b exp=0100", io_if.in_ready);
    end
    step();
    io_if.in_valid = '0;
    #1;
    checks++;
    if (io_if.out_valid !== 1'b1 || io_if.out_bits !== 10'h155 || io_if.out_src !== 2'd2) begin
      failures++;
      $display("[TB] FAIL single_out got=%b/%h/%0d exp=1/155/2",
               io_if.out_valid, io_if.out_bits, io_if.out_src);
    end
    checks++;
    if (grant_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL single_cnt got=%0d exp=1", grant_cnt);
    end
    step();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_bits(i, 10'(10'h3F0 + i));
    io_if.in_valid  = 4'b1111;
    io_if.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (io_if.in_ready !== 4'(1 << (c % 4))) begin
        failures++;
        $display("[TB] FAIL rr_ready cyc=%0d got=%b exp=%b", c, io_if.in_ready, 4'(1 << (c % 4)));
      end
      step();
      checks++;
      if (io_if.out_src !== 2'(c % 4) || io_if.out_bits !== 10'(10'h3F0 + (c % 4))) begin
        failures++;
        $display("[TB] FAIL rr_out cyc=%0d got=%0d/%h exp=%0d/%h", c, io_if.out_src,
                 io_if.out_bits, c % 4, 10'(10'h3F0 + (c % 4)));
      end
    end
    checks++;
    if (grant_cnt !== 16'd8) begin
      failures++;
      $display("[TB] FAIL rr_cnt got=%0d exp=8", grant_cnt);
    end
    io_if.in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    io_if.out_ready = 1'b1;
    io_if.in_valid  = 4'b0010;
    set_bits(1, 10'h2AA);
    step();
    for (int i = 0; i < NUM_REQ; i++) set_bits(i, 10'(10'h100 + i));
    io_if.in_valid  = 4'b1111;
    io_if.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (io_if.in_ready !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=0000", c, io_if.in_ready);
      end
      step();
      checks++;
      if (io_if.out_valid !== 1'b1 || io_if.out_bits !== 10'h2AA || io_if.out_src !== 2'd1) begin
        failures++;
        $display("[TB] FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1/2aa/1", c,
                 io_if.out_valid, io_if.out_bits, io_if.out_src);
      end
    end
    io_if.out_ready = 1'b1;
    #1;
    checks++;
    if (io_if.in_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL bp_release_ready got=%b exp=0100", io_if.in_ready);
    end
    step();
    checks++;
    if (io_if.out_src !== 2'd2 || io_if.out_bits !== 10'h102) begin
      failures++;
      $display("[TB] FAIL bp_release_out got=%0d/%h exp=2/102", io_if.out_src, io_if.out_bits);
    end
  endtask

  // Continues from the FULL src=2 / 0x102 / cnt=2 state left by test_backpressure.
  task automatic test_drain();
    io_if.in_valid  = '0;
    io_if.out_ready = 1'b1;
    #1;
    checks++;
    if (io_if.in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL drain_ready got=%b exp=0000", io_if.in_ready);
    end
    step();
    checks++;
    if (io_if.out_valid !== 1'b0 || io_if.out_bits !== 10'h102 || io_if.out_src !== 2'd2) begin
      failures++;
      $display("[TB] FAIL drain_out got=%b/%h/%0d exp=0/102/2",
               io_if.out_valid, io_if.out_bits, io_if.out_src);
    end
    checks++;
    if (grant_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL drain_cnt got=%0d exp=2", grant_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    io_if.out_ready = 1'b1;
    io_if.in_valid  = 4'b0001;
    step();
    io_if.in_valid  = 4'b0010;
    step();
    io_if.in_valid  = 4'b1010;
    reset = 1'b0;
    #1;
    checks++;
    if (io_if.in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL mid_reset_ready got=%b exp=0000", io_if.in_ready);
    end
    step();
    reset = 1'b1;
    checks++;
    if (io_if.out_valid !== 1'b0 || grant_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_state got=%b/%0d exp=0/0", io_if.out_valid, grant_cnt);
    end
    #1;
    checks++;
    if (io_if.in_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL mid_first_ready got=%b exp=0010", io_if.in_ready);
    end
    step();
    checks++;
    if (io_if.out_src !== 2'd1 || grant_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL mid_first_grant got=%0d/%0d exp=1/1", io_if.out_src, grant_cnt);
    end
    // Stream one word per cycle until the counter reaches 0xFFFF, then wrap it.
    io_if.in_valid = 4'b1111;
    repeat (65534) @(posedge clock);
    @(negedge clock);
    checks++;
    if (grant_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL wrap_pre got=%h exp=ffff", grant_cnt);
    end
    step();
    checks++;
    if (grant_cnt !== 16'h0000 || io_if.out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_post got=%h/%b exp=0000/1", grant_cnt, io_if.out_valid);
    end
    io_if.in_valid = '0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    io_if.in_valid  = '0;
    io_if.in_bits   = '0;
    io_if.out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
